// File: rtl/popcount_frame_accumulator.sv
// Sums FRAME_LEN per-sample ones counts (0..4) into a saturating frame total and
// presents it on a held valid/ready output. Optional macro: POPCOUNT_RANGE_CHECK_EN.
module popcount_frame_accumulator #(
    parameter int FRAME_LEN = 8,
    parameter int ACC_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           count_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ACC_WIDTH-1:0] total,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 saturated,
    output logic [7:0]           sample_idx,
`ifdef POPCOUNT_RANGE_CHECK_EN
    output logic                 range_err,
`endif
    output logic                 state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1. in_ready depends on state only; total/saturated hold while out_valid=1.

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    localparam int                 SW       = ACC_WIDTH + 3;
    localparam logic [SW-1:0]      MAX_EXT  = SW'({ACC_WIDTH{1'b1}});
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {ACC_WIDTH{1'b1}};
    localparam logic [7:0]         LAST_IDX = 8'(FRAME_LEN - 1);

    logic [0:0]           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [7:0]           idx_q, idx_d;
    logic                 sat_q, sat_d;
    logic [ACC_WIDTH-1:0] total_q, total_d;
    logic                 out_sat_q, out_sat_d;
    logic                 range_err_q, range_err_d;

    logic                 accept;
    logic                 out_of_range;
    logic [2:0]           add_val;
    logic [SW-1:0]        sum_ext;
    logic                 overflow;
    logic [ACC_WIDTH-1:0] acc_sum;

    always_comb begin
        accept = in_valid && (state_q == ST_ACCUM);
`ifdef POPCOUNT_RANGE_CHECK_EN
        out_of_range = (count_in > 3'd4);
        add_val      = out_of_range ? 3'd0 : count_in;
`else
        out_of_range = 1'b0;
        add_val      = count_in;
`endif
        // Extra headroom bits let the clamp see any overflow from one add.
        sum_ext  = SW'(acc_q) + SW'(add_val);
        overflow = (sum_ext > MAX_EXT);
        acc_sum  = overflow ? ACC_MAX : sum_ext[ACC_WIDTH-1:0];
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        sat_d       = sat_q;
        total_d     = total_q;
        out_sat_d   = out_sat_q;
        range_err_d = range_err_q | (accept & out_of_range);
        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        total_d   = acc_sum;
                        out_sat_d = sat_q | overflow;
                        acc_d     = '0;
                        idx_d     = 8'd0;
                        sat_d     = 1'b0;
                        state_d   = ST_HOLD;
                    end else begin
                        acc_d = acc_sum;
                        idx_d = idx_q + 8'd1;
                        sat_d = sat_q | overflow;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            idx_q       <= 8'd0;
            sat_q       <= 1'b0;
            total_q     <= '0;
            out_sat_q   <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            sat_q       <= sat_d;
            total_q     <= total_d;
            out_sat_q   <= out_sat_d;
            range_err_q <= range_err_d;
        end
    end

    assign in_ready   = (state_q == ST_ACCUM);
    assign out_valid  = (state_q == ST_HOLD);
    assign total      = total_q;
    assign saturated  = out_sat_q;
    assign sample_idx = idx_q;
    assign state_dbg  = state_q[0];
`ifdef POPCOUNT_RANGE_CHECK_EN
    assign range_err  = range_err_q;
`else
    logic unused_range;
    assign unused_range = range_err_q;
`endif

endmodule
